// File: rtl/tow_match_ctrl_if.sv
// Signal bundle between the board-side match control and the tug-of-war round sequencer.
// master drives start and the round datapath results; slave is the sequencer.
interface tow_match_ctrl_if #(
    parameter int SCORE_W = 3
);
    logic               start;
    logic               winrnd;
    logic               right;
    logic               tie;
    logic               clr;
    logic               arm;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [3:0]         round_no;
    logic               timeout;
    logic               match_done;
    logic               winner_r;

    modport master (
        output start, winrnd, right, tie,
        input  clr, arm, score_l, score_r, round_no, timeout, match_done, winner_r
    );

    modport slave (
        input  start, winrnd, right, tie,
        output clr, arm, score_l, score_r, round_no, timeout, match_done, winner_r
    );
endinterface

// File: rtl/tow_match_ctrl.sv
// Match-level sequencer for the tug-of-war round datapath: clears rounds, arms play,
// scores results, enforces post-round hold and per-round timeout, declares the winner.
module tow_match_ctrl #(
    parameter int ROUNDS_TO_WIN = 3,
    parameter int SCORE_W       = 3,
    parameter int HOLD_CYC      = 8,
    parameter int TMO_CYC       = 1000,
    parameter int TMO_W         = 10
) (
    input logic             clk,
    input logic             rst,
    tow_match_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, PLAY, HOLD, DONE} state_t;

    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0]   HOLD_LAST = TMO_W'(HOLD_CYC - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(ROUNDS_TO_WIN);

    state_t             state;
    logic [TMO_W-1:0]   timer;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [3:0]         round_no;
    logic               timeout;
    logic               winner_r;
    logic [3:0]         round_inc;
    logic               live;

    assign round_inc = (round_no == 4'd15) ? round_no : round_no + 4'd1;
    // First PLAY cycle still sees the previous round's datapath outputs.
    assign live      = (timer != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            score_l  <= '0;
            score_r  <= '0;
            round_no <= '0;
            timeout  <= 1'b0;
            winner_r <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= CLEAR;
                        score_l  <= '0;
                        score_r  <= '0;
                        round_no <= '0;
                    end
                end
                CLEAR: begin
                    timer <= '0;
                    state <= PLAY;
                end
                PLAY: begin
                    timer <= timer + TMO_W'(1);
                    if (live && bus.tie) begin
                        round_no <= round_inc;
                        timer    <= '0;
                        state    <= HOLD;
                    end else if (live && bus.winrnd) begin
                        if (bus.right) score_r <= score_r + SCORE_W'(1);
                        else           score_l <= score_l + SCORE_W'(1);
                        round_no <= round_inc;
                        timer    <= '0;
                        state    <= HOLD;
                    end else if (timer == TMO_LAST) begin
                        timeout  <= 1'b1;
                        round_no <= round_inc;
                        timer    <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    timer <= timer + TMO_W'(1);
                    if (timer == HOLD_LAST) begin
                        timer <= '0;
                        if (score_l == WIN_SCORE || score_r == WIN_SCORE) begin
                            winner_r <= (score_r == WIN_SCORE);
                            state    <= DONE;
                        end else begin
                            state <= CLEAR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.clr        = (state == CLEAR);
    assign bus.arm        = (state == PLAY);
    assign bus.match_done = (state == DONE);
    assign bus.score_l    = score_l;
    assign bus.score_r    = score_r;
    assign bus.round_no   = round_no;
    assign bus.timeout    = timeout;
    assign bus.winner_r   = winner_r;
endmodule
